edge_event_arbiter: RTL and testbench

Collects rising/falling edges from `CHANNELS` asynchronous input lines, records each as a pending event, and presents them one at a time to a single downstream consumer over a valid/ready handshake. Channels are served round-robin. Per-channel enable masks configure which edge types are recorded. Lost edges are flagged in sticky overflow bits. The block sits between raw external lines (buttons, strobes, interrupt pins) and a shared event-processing datapath.

---
 rtl/edge_event_arbiter_pkg.sv | 14 +
 rtl/edge_event_arbiter_sync_det.sv | 29 ++
 rtl/edge_event_arbiter.sv | 148 ++++++++++++++
 tb/tb_edge_event_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/edge_event_arbiter_pkg.sv
// Shared constants and types for the edge event arbiter: settle length,
// evt_rising encodings and the output-stage state type.
package edge_event_arbiter_pkg;

   localparam int   SETTLE_LEN = 3;
   localparam logic EVT_RISE   = 1'b1;
   localparam logic EVT_FALL   = 1'b0;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_t;

endpackage

// File: rtl/edge_event_arbiter_sync_det.sv
// Per-channel 2-flop synchroniser, delay flop and edge detector.
// A high mask suppresses both edge outputs (used during post-reset settle).
module edge_sync_det (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   input  logic mask,
   output logic pedge,
   output logic nedge
);

   logic s0, s1, d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0 <= 1'b0;
         s1 <= 1'b0;
         d  <= 1'b0;
      end else begin
         s0 <= in;
         s1 <= s0;
         d  <= s1;
      end
   end

   assign pedge = ~mask &  s1 & ~d;
   assign nedge = ~mask & ~s1 &  d;

endmodule

// File: rtl/edge_event_arbiter.sv
// Records enabled edges from CHANNELS async lines as pending events and
// presents them one at a time, round-robin, over a valid/ready handshake.
module edge_event_arbiter
   import edge_event_arbiter_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int IDX_W    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] in,
   input  logic [CHANNELS-1:0] pos_en,
   input  logic [CHANNELS-1:0] neg_en,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [IDX_W-1:0]    evt_chan,
   output logic                evt_rising,
   output logic [CHANNELS-1:0] overflow,
   input  logic                ovf_clr
);

   logic [1:0]          settle_cnt;
   logic                settling;
   logic [CHANNELS-1:0] pedge, nedge;
   logic [CHANNELS-1:0] pr, pf, ord;
   logic [CHANNELS-1:0] pr_nxt, pf_nxt, ord_nxt, ovf_nxt;
   logic [IDX_W-1:0]    last_grant, grant;
   logic                found, grant_rise, load;
   arb_state_t          state, state_nxt;

   // Edge detection stays gated until the sync pipeline has refilled after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         settle_cnt <= 2'd0;
      else if (settling)
         settle_cnt <= settle_cnt + 2'd1;
   end

   assign settling = (settle_cnt != 2'(SETTLE_LEN));

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_det
      edge_sync_det u_det (
         .clk   (clk),
         .rst_n (rst_n),
         .in    (in[ch]),
         .mask  (settling),
         .pedge (pedge[ch]),
         .nedge (nedge[ch])
      );
   end

   always_comb begin
      int idx;
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int i = 1; i <= CHANNELS; i++) begin
         idx = (int'(last_grant) + i) % CHANNELS;
         if (!found && (pr[idx] || pf[idx])) begin
            found = 1'b1;
            grant = IDX_W'(idx);
         end
      end
   end

   // With both edges pending, ord picks the older one.
   assign grant_rise = pr[grant] & (~pf[grant] | ord[grant]);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (found) begin
               load      = 1'b1;
               state_nxt = ARB_HOLD;
            end
         end
         ARB_HOLD: begin
            if (evt_ready) begin
               load      = found;
               state_nxt = found ? ARB_HOLD : ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ARB_IDLE;
      else
         state <= state_nxt;
   end

   assign evt_valid = (state == ARB_HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_chan   <= '0;
         evt_rising <= EVT_FALL;
         last_grant <= IDX_W'(CHANNELS - 1);
      end else if (load) begin
         evt_chan   <= grant;
         evt_rising <= grant_rise ? EVT_RISE : EVT_FALL;
         last_grant <= grant;
      end
   end

   // A bit consumed this cycle may be re-set by a new edge without overflow.
   always_comb begin
      logic take_r, take_f, keep_r, keep_f;
      pr_nxt  = '0;
      pf_nxt  = '0;
      ord_nxt = '0;
      ovf_nxt = '0;
      take_r  = 1'b0;
      take_f  = 1'b0;
      keep_r  = 1'b0;
      keep_f  = 1'b0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         take_r      = load && (grant == IDX_W'(ch)) &&  grant_rise;
         take_f      = load && (grant == IDX_W'(ch)) && !grant_rise;
         keep_r      = pr[ch] & ~take_r & pos_en[ch];
         keep_f      = pf[ch] & ~take_f & neg_en[ch];
         pr_nxt[ch]  = pos_en[ch] & (pedge[ch] | keep_r);
         pf_nxt[ch]  = neg_en[ch] & (nedge[ch] | keep_f);
         ord_nxt[ch] = (keep_r & keep_f) ? ord[ch] : keep_r;
         ovf_nxt[ch] = (pedge[ch] & keep_r) | (nedge[ch] & keep_f) |
                       (overflow[ch] & ~ovf_clr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pr       <= '0;
         pf       <= '0;
         ord      <= '0;
         overflow <= '0;
      end else begin
         pr       <= pr_nxt;
         pf       <= pf_nxt;
         ord      <= ord_nxt;
         overflow <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomised + directed bench for edge_event_arbiter: a timestamp-based
// reference model feeds an expected-event queue checked by a monitor.
module tb_edge_event_arbiter;

   localparam int CH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CH-1:0] din = '1;
   logic [CH-1:0] pos_en = '1;
   logic [CH-1:0] neg_en = '1;
   logic          evt_ready = 1'b1;
   logic          ovf_clr = 1'b0;
   logic          evt_valid;
   logic [1:0]    evt_chan;
   logic          evt_rising;
   logic [CH-1:0] overflow;

   int ntests = 0;
   int nfail  = 0;

   typedef struct { int ch; bit rise; } evt_t;
   evt_t exp_q[$];

   // reference model state
   bit            m_pr[CH], m_pf[CH];
   int            m_tr[CH], m_tf[CH];
   logic [CH-1:0] m_ovf;
   int            m_ptr, m_e, m_och;
   bit            m_ov, m_orise;
   logic [CH-1:0] m_hist[$];

   edge_event_arbiter #(.CHANNELS(CH), .IDX_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (din),
      .pos_en     (pos_en),
      .neg_en     (neg_en),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_chan   (evt_chan),
      .evt_rising (evt_rising),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_pr[c] = 0; m_pf[c] = 0; m_tr[c] = 0; m_tf[c] = 0;
      end
      m_ovf = '0; m_ptr = CH - 1; m_e = 0;
      m_ov = 0; m_och = 0; m_orise = 0;
      m_hist.delete();
      exp_q.delete();
   endtask

   // One clock edge: edges are changes between samples two and three edges
   // old, ignored for the first three edges after reset release.
   task automatic model_edge();
      logic [CH-1:0] rd, fd, s1, d;
      bit found, grise, load_en, tr, tf, drop;
      int g, c;
      m_e++;
      rd = '0; fd = '0;
      if (m_e >= 4) begin
         s1 = m_hist[m_hist.size()-2];
         d  = m_hist[m_hist.size()-3];
         rd = s1 & ~d;
         fd = ~s1 & d;
      end
      load_en = !m_ov || evt_ready;
      found = 0; g = 0;
      if (load_en)
         for (int i = 1; i <= CH; i++) begin
            c = (m_ptr + i) % CH;
            if (!found && (m_pr[c] || m_pf[c])) begin found = 1; g = c; end
         end
      grise = m_pr[g] && (!m_pf[g] || m_tr[g] < m_tf[g]);
      for (int k = 0; k < CH; k++) begin
         tr = found && g == k && grise;
         tf = found && g == k && !grise;
         drop = 0;
         if (!pos_en[k]) m_pr[k] = 0;
         else if (rd[k]) begin
            if (m_pr[k] && !tr) drop = 1;
            else begin m_pr[k] = 1; m_tr[k] = m_e; end
         end else if (tr) m_pr[k] = 0;
         if (!neg_en[k]) m_pf[k] = 0;
         else if (fd[k]) begin
            if (m_pf[k] && !tf) drop = 1;
            else begin m_pf[k] = 1; m_tf[k] = m_e; end
         end else if (tf) m_pf[k] = 0;
         if (drop) m_ovf[k] = 1'b1;
         else if (ovf_clr) m_ovf[k] = 1'b0;
      end
      if (load_en) begin
         m_ov = found;
         if (found) begin
            m_och = g; m_orise = grise; m_ptr = g;
            exp_q.push_back('{ch: g, rise: grise});
         end
      end
      m_hist.push_back(din);
      if (m_hist.size() > 3) void'(m_hist.pop_front());
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_edge();
      end
   end

   // Monitor: compares presented outputs and pops each accepted event.
   initial begin
      evt_t e;
      forever begin
         @(negedge clk);
         chk("evt_valid", 32'(evt_valid), 32'(m_ov));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         if (m_ov) begin
            chk("evt_chan", 32'(evt_chan), 32'(m_och));
            chk("evt_rising", 32'(evt_rising), 32'(m_orise));
         end
         if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
               ntests++; nfail++;
               $display("FAIL sb_unexpected: got chan %0d rising %0d expected no event", evt_chan, evt_rising);
            end else begin
               e = exp_q.pop_front();
               chk("sb_chan", 32'(evt_chan), 32'(e.ch));
               chk("sb_rising", 32'(evt_rising), 32'(e.rise));
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      cycles(3);
      chk("reset_valid", 32'(evt_valid), 32'd0);
      chk("reset_chan", 32'(evt_chan), 32'd0);
      chk("reset_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      cycles(12);
      chk("held_high_no_evt", 32'(evt_valid), 32'd0);
      din = 4'b0000;
      cycles(12);
      // single edge on channel 2: valid right after edge k+3
      din[2] = 1'b1;
      cycles(3);
      chk("lat_not_yet", 32'(evt_valid), 32'd0);
      cycles(1);
      chk("lat_valid", 32'(evt_valid), 32'd1);
      chk("lat_chan", 32'(evt_chan), 32'd2);
      chk("lat_rising", 32'(evt_rising), 32'd1);
      cycles(1);
      chk("single_done", 32'(evt_valid), 32'd0);
      // round robin bursts
      din = 4'b1111; cycles(8);
      din = 4'b0100; cycles(8);
      din = 4'b1111; cycles(8);
      // backpressure on channel 1
      evt_ready = 1'b0;
      din[1] = 1'b0;
      cycles(12);
      chk("bp_frozen_chan", 32'(evt_chan), 32'd1);
      evt_ready = 1'b1;
      cycles(6);
      // overflow on channel 0, rises only
      neg_en[0] = 1'b0;
      din[0] = 1'b0; cycles(6);
      evt_ready = 1'b0;
      repeat (3) begin din[0] = 1'b1; cycles(3); din[0] = 1'b0; cycles(3); end
      cycles(2);
      chk("ovf_set", 32'(overflow), 32'h1);
      ovf_clr = 1'b1; cycles(1); ovf_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'h0);
      evt_ready = 1'b1; neg_en[0] = 1'b1;
      cycles(6);
      // mask: fall on channel 3 ignored, then rise-before-fall ordering
      neg_en[3] = 1'b0;
      din[3] = 1'b0; cycles(2); din[3] = 1'b1; cycles(2); din[3] = 1'b0; cycles(8);
      neg_en[3] = 1'b1; evt_ready = 1'b0;
      din[3] = 1'b1; cycles(2); din[3] = 1'b0; cycles(6);
      evt_ready = 1'b1; cycles(6);
      // reset mid-operation with lines high
      evt_ready = 1'b0; din = 4'b0000; cycles(6);
      rst_n = 1'b0; din = 4'hF; cycles(2);
      chk("midrst_valid", 32'(evt_valid), 32'd0);
      chk("midrst_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1; evt_ready = 1'b1; cycles(10);
      chk("midrst_no_evt", 32'(evt_valid), 32'd0);
      // randomised traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int b = 0; b < CH; b++)
            if ($urandom_range(0, 5) == 0) din[b] = ~din[b];
         evt_ready = ($urandom_range(0, 3) != 0);
         ovf_clr   = ($urandom_range(0, 31) == 0);
         if (cyc % 250 == 0) begin
            pos_en = 4'($urandom) | 4'($urandom);
            neg_en = 4'($urandom) | 4'($urandom);
         end
         if (cyc == 1500) rst_n = 1'b0;
         if (cyc == 1503) rst_n = 1'b1;
         cycles(1);
      end
      evt_ready = 1'b1; ovf_clr = 1'b0;
      cycles(30);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
